fir_decim_ctrl: RTL and testbench
=================================

Name: fir_decim_ctrl

Overview:
- Sequencing controller for the 17-tap FIR low-pass in the FM demodulator chain.
- Accepts input samples over a valid/ready handshake and drives the FIR's data and strobe inputs with one strobe per accepted sample.
- Discards the FIR warm-up transient, decimates the filtered stream by DECIM, and presents results on a held valid/ready output register with sticky overflow detection.

Parameters:
- WIDTH, 16: sample width, signed two's complement, both in and out.
- DECIM, 4: decimation factor, legal range 1..256; 1 means pass every result.
- WARMUP, 18: number of initial FIR results discarded after enable (17 taps + 1 pipeline stage).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- enable_i  in  1  run enable; low forces IDLE.
- sample_valid_i  in  1  input sample valid.
- sample_i  in  WIDTH  input sample, signed.
- sample_ready_o  out  1  controller can accept a sample.
- fir_data_o  out  WIDTH  sample to FIR data input.
- fir_start_o  out  1  FIR start strobe.
- fir_merge_o  out  1  FIR merge-finished strobe; always identical to fir_start_o.
- fir_result_i  in  WIDTH  FIR output, registered inside the FIR.
- out_valid_o  out  1  decimated result valid.
- out_data_o  out  WIDTH  decimated result, signed.
- out_ready_i  in  1  downstream accepts the result.
- overflow_o  out  1  sticky flag: a result was dropped.

Behaviour:
- Reset (rst low, asynchronous) forces every output to 0 immediately, sets state to IDLE, and clears all counters.
- States:
  - IDLE: entered from reset or when enable_i is low; goes to FILL on enable_i high.
  - FILL: goes to RUN when fill_cnt reaches WARMUP.
  - RUN: decimating.
  - enable_i low in FILL or RUN: next state IDLE. fill_cnt, phase, the strobe pipeline and overflow_o clear. A pending out_valid_o stays until consumed.
- sample_ready_o is 1 in FILL and RUN, 0 in IDLE. It does not depend on out_ready_i, because the FIR cannot be stalled.
- Accept: sample_valid_i & sample_ready_o at edge t.
  - In cycle t+1: fir_data_o = sample_i (registered), and fir_start_o = fir_merge_o = 1 for exactly one cycle.
  - fir_data_o holds its value between strobes.
  - Back-to-back accepts produce back-to-back strobes.
- Capture: fir_result_i is sampled in the cycle after each strobe (t+2), using a 1-bit strobe delay register.
- FILL: each capture increments fill_cnt. Captures 1..WARMUP are discarded. The transition to RUN occurs on the WARMUP-th capture.
- RUN: phase counter runs 0..DECIM-1, incremented per capture and wrapping at DECIM-1. A capture with phase==0 is emitted; the others are discarded.
  - The first RUN capture (overall capture WARMUP+1) has phase 0.
- Output register: out_data_o and out_valid_o are loaded at t+3 relative to the accept that produced them.
  - A transfer happens when out_valid_o & out_ready_i.
  - Emit while out_valid_o=0: load, set valid.
  - Emit while out_valid_o=1 & out_ready_i=1: load the new value, valid stays 1.
  - Emit while out_valid_o=1 & out_ready_i=0: drop the new value, keep the old, set overflow_o.
  - No emit and a transfer: valid goes to 0, out_data_o holds.
- overflow_o clears only on reset or on the RUN/FILL to IDLE transition.
- Counter widths: clog2(WARMUP+1) bits for fill_cnt, clog2(DECIM) bits (minimum 1) for phase.
- Latency: accept to out_valid_o is 3 cycles for an emitted sample.

Optional Feature:
- Macro: FIR_DECIM_CTRL_STATS_EN.
- Defined:
  - Adds output ports in_count_o [31:0] (accepted samples) and drop_count_o [15:0] (dropped results).
  - Both are wrapping counters, cleared on reset only.
  - drop_count_o increments on the same event that sets overflow_o.
- Undefined: the ports and counters are absent; the rest of the block is identical.

Decomposition:
- Shared package fir_ctrl_pkg:
  - state enum (IDLE, FILL, RUN);
  - localparam FIR_TAPS=17;
  - localparam FIR_PIPE=1;
  - default WARMUP derived as FIR_TAPS+FIR_PIPE.
- Sub-module fir_decim_outreg: the single-entry valid/ready holding register with overflow detection, instantiated once.
- The FSM and counters stay in the top module.

Test Plan:
- Reset then enable, no input: sample_ready_o=1, fir_start_o=0, out_valid_o=0 indefinitely; assert rst low mid-run: all outputs 0 within the same cycle.
- DECIM=4, WARMUP=18, 40 consecutive samples, out_ready_i=1, fir_result_i driven as capture index: outputs 19,23,27,31,35,39; first out_valid_o 3 cycles after accept #19.
- Sample 0x7FFF accepted: next cycle fir_data_o=0x7FFF, fir_start_o=fir_merge_o=1 for one cycle; a gap in sample_valid_i gives no strobe.
- DECIM=1, out_ready_i=0 after warm-up: first result held, second result dropped, overflow_o=1, out_data_o unchanged; out_ready_i=1 then completes the transfer while overflow_o stays 1.
- enable_i drop during FILL at capture 10, re-enable: 18 fresh discards before the first output; overflow_o and phase cleared.
- With FIR_DECIM_CTRL_STATS_EN: 40 accepts and 3 drops give in_count_o=40, drop_count_o=3; compile without the macro: ports absent, other results match.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR decimation controller.
package fir_ctrl_pkg;

    localparam int unsigned FIR_TAPS       = 17;
    localparam int unsigned FIR_PIPE       = 1;
    localparam int unsigned WARMUP_DEFAULT = FIR_TAPS + FIR_PIPE;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StRun  = 2'd2
    } state_e;

    // Counter width for values 0..n-1, never below one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_decim_ctrl_if.sv
// Sample-in and result-out valid/ready streams of the FIR decimation controller.
interface fir_decim_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             sample_valid_i;
    logic [WIDTH-1:0] sample_i;
    logic             sample_ready_o;
    logic             out_valid_o;
    logic [WIDTH-1:0] out_data_o;
    logic             out_ready_i;

    // Controller side
    modport slave (
        input  sample_valid_i, sample_i, out_ready_i,
        output sample_ready_o, out_valid_o, out_data_o
    );

    // Producer/consumer side
    modport master (
        output sample_valid_i, sample_i, out_ready_i,
        input  sample_ready_o, out_valid_o, out_data_o
    );
endinterface

// File: rtl/fir_decim_outreg.sv
// Single-entry valid/ready result register; a result arriving while the held one is
// stalled is dropped and flagged in a sticky overflow bit.
module fir_decim_outreg #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             emit_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             clr_ovf_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             overflow_o,
    output logic             drop_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;

    // Load, hold, drop or release the held result
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        drop_o  = 1'b0;
        if (emit_i) begin
            if (!valid_q || out_ready_i) begin
                valid_d = 1'b1;
                data_d  = data_i;
            end else begin
                drop_o = 1'b1;
                ovf_d  = 1'b1;
            end
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
        if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
    end

    // Holding register state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign overflow_o  = ovf_q;

endmodule

// File: rtl/fir_decim_ctrl.sv
// Sequencing controller for the 17-tap FM-demod FIR: strobes the FIR once per accepted
// sample, discards the warm-up transient and decimates the filtered stream by DECIM.
// Optional statistics counters: define FIR_DECIM_CTRL_STATS_EN.
module fir_decim_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DECIM  = 4,
    parameter int unsigned WARMUP = WARMUP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    fir_decim_ctrl_if.slave  io,
    output logic [WIDTH-1:0] fir_data_o,
    output logic             fir_start_o,
    output logic             fir_merge_o,
    input  logic [WIDTH-1:0] fir_result_i,
    output logic             overflow_o
`ifdef FIR_DECIM_CTRL_STATS_EN
    ,
    output logic [31:0]      in_count_o,
    output logic [15:0]      drop_count_o
`endif
);

    localparam int unsigned       FillW     = cnt_width(WARMUP + 1);
    localparam int unsigned       PhaseW    = cnt_width(DECIM);
    localparam logic [FillW-1:0]  FillLast  = FillW'(WARMUP - 1);
    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(DECIM - 1);

    state_e              state_q, state_d;
    logic [FillW-1:0]    fill_cnt_q, fill_cnt_d;
    logic [PhaseW-1:0]   phase_q, phase_d;
    logic [WIDTH-1:0]    data_q;
    logic                strobe_q, strobe_dly_q;
    logic                sample_ready;
    logic                accept, capture, emit, drop;
    logic                out_valid;
    logic [WIDTH-1:0]    out_data;

    assign accept  = io.sample_valid_i & sample_ready;
    // FIR result is registered, so it is valid the cycle after the strobe
    assign capture = strobe_dly_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; enable low always wins
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable_i) state_d = StFill;
            StFill:  if (capture && (fill_cnt_q == FillLast)) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StIdle;
        endcase
        if (!enable_i) begin
            state_d = StIdle;
        end
    end

    // Output decode: the FIR cannot stall, so readiness ignores downstream
    always_comb begin
        sample_ready = (state_q == StFill) || (state_q == StRun);
    end

    // Warm-up and decimation counters; emit on phase zero in RUN
    always_comb begin
        fill_cnt_d = fill_cnt_q;
        phase_d    = phase_q;
        emit       = 1'b0;
        if (!enable_i || (state_q == StIdle)) begin
            fill_cnt_d = '0;
            phase_d    = '0;
        end else if (capture) begin
            if (state_q == StFill) begin
                fill_cnt_d = fill_cnt_q + 1'b1;
            end else begin
                emit    = (phase_q == '0);
                phase_d = (phase_q == PhaseLast) ? '0 : phase_q + 1'b1;
            end
        end
    end

    // FIR data/strobe pipeline and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q       <= '0;
            strobe_q     <= 1'b0;
            strobe_dly_q <= 1'b0;
            fill_cnt_q   <= '0;
            phase_q      <= '0;
        end else begin
            if (accept && enable_i) begin
                data_q <= io.sample_i;
            end
            strobe_q     <= accept & enable_i;
            strobe_dly_q <= strobe_q & enable_i;
            fill_cnt_q   <= fill_cnt_d;
            phase_q      <= phase_d;
        end
    end

    fir_decim_outreg #(
        .WIDTH (WIDTH)
    ) u_outreg (
        .clk         (clk),
        .rst         (rst),
        .emit_i      (emit),
        .data_i      (fir_result_i),
        .clr_ovf_i   ((state_q != StIdle) && !enable_i),
        .out_ready_i (io.out_ready_i),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .overflow_o  (overflow_o),
        .drop_o      (drop)
    );

    assign io.sample_ready_o = sample_ready;
    assign io.out_valid_o    = out_valid;
    assign io.out_data_o     = out_data;
    assign fir_data_o        = data_q;
    assign fir_start_o       = strobe_q;
    assign fir_merge_o       = strobe_q;

`ifdef FIR_DECIM_CTRL_STATS_EN
    logic [31:0] in_count_q;
    logic [15:0] drop_count_q;

    // Wrapping statistics counters, cleared by reset only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_count_q   <= '0;
            drop_count_q <= '0;
        end else begin
            if (accept) in_count_q <= in_count_q + 32'd1;
            if (drop) drop_count_q <= drop_count_q + 16'd1;
        end
    end

    assign in_count_o   = in_count_q;
    assign drop_count_o = drop_count_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_fir_decim_ctrl.sv
// Directed bench for fir_decim_ctrl: two instances (DECIM=4 and DECIM=1) share stimulus
// and a FIR stand-in whose output is the running strobe count.
module tb_fir_decim_ctrl;

    localparam int unsigned W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic [W-1:0]  fir_res = '0;
    logic [W-1:0]  fir_data4, fir_data1;
    logic          start4, merge4, start1, merge1, ovf4, ovf1;
`ifdef FIR_DECIM_CTRL_STATS_EN
    logic [31:0]   inc4, inc1;
    logic [15:0]   drc4, drc1;
`endif

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            first_v4 = -1;
    int            acc19 = 0;
    logic [W-1:0]  q4[$];
    logic [W-1:0]  q1[$];

    fir_decim_ctrl_if #(.WIDTH(W)) io4 ();
    fir_decim_ctrl_if #(.WIDTH(W)) io1 ();

    fir_decim_ctrl #(.WIDTH(W), .DECIM(4), .WARMUP(18)) u_dut4 (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable),
        .io           (io4),
        .fir_data_o   (fir_data4),
        .fir_start_o  (start4),
        .fir_merge_o  (merge4),
        .fir_result_i (fir_res),
        .overflow_o   (ovf4)
`ifdef FIR_DECIM_CTRL_STATS_EN
        ,
        .in_count_o   (inc4),
        .drop_count_o (drc4)
`endif
    );

    fir_decim_ctrl #(.WIDTH(W), .DECIM(1), .WARMUP(18)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable),
        .io           (io1),
        .fir_data_o   (fir_data1),
        .fir_start_o  (start1),
        .fir_merge_o  (merge1),
        .fir_result_i (fir_res),
        .overflow_o   (ovf1)
`ifdef FIR_DECIM_CTRL_STATS_EN
        ,
        .in_count_o   (inc1),
        .drop_count_o (drc1)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIR stand-in: registered output advances once per strobe, so capture k sees k
    always @(posedge clk) begin
        if (!rst) fir_res <= '0;
        else if (start4) fir_res <= fir_res + 1'b1;
    end

    // Record every completed output transfer
    always @(posedge clk) begin
        if (io4.out_valid_o && io4.out_ready_i) q4.push_back(io4.out_data_o);
        if (io1.out_valid_o && io1.out_ready_i) q1.push_back(io1.out_data_o);
    end

    // First cycle the DECIM=4 output becomes valid
    always @(negedge clk) begin
        if (io4.out_valid_o && (first_v4 < 0)) first_v4 = cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d);
        io4.sample_valid_i = v;
        io4.sample_i       = d;
        io1.sample_valid_i = v;
        io1.sample_i       = d;
    endtask

    task automatic set_ready(input logic r);
        io4.out_ready_i = r;
        io1.out_ready_i = r;
    endtask

    function automatic logic [31:0] q4_at(input int k);
        return (k < q4.size()) ? 32'(q4[k]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] q1_at(input int k);
        return (k < q1.size()) ? 32'(q1[k]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        drive(1'b0, '0);
        set_ready(1'b1);
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(io4.sample_ready_o), 0);
        check("rst_start", 32'(start4), 0);
        check("rst_valid", 32'(io4.out_valid_o), 0);
        check("rst_ovf", 32'(ovf4), 0);
        check("rst_fir_data", 32'(fir_data4), 0);

        rst = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(io4.sample_ready_o), 0);

        // Enabled with no input: ready, but nothing moves
        enable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("en_ready", 32'(io4.sample_ready_o), 1);
            check("en_nostrobe", 32'(start4), 0);
            check("en_novalid", 32'(io4.out_valid_o), 0);
        end

        // Full-scale sample, then a gap
        drive(1'b1, 16'h7FFF);
        @(negedge clk);
        drive(1'b0, '0);
        check("max_data", 32'(fir_data4), 32'h7FFF);
        check("max_start", 32'(start4), 1);
        check("max_merge", 32'(merge4), 1);
        @(negedge clk);
        check("gap_start", 32'(start4), 0);
        check("gap_merge", 32'(merge4), 0);
        check("gap_hold_data", 32'(fir_data4), 32'h7FFF);
        @(negedge clk);
        check("gap_start2", 32'(start4), 0);

        // Samples 2..40 back to back
        for (int i = 2; i <= 40; i++) begin
            drive(1'b1, W'(i));
            if (i == 19) acc19 = cyc;
            @(negedge clk);
            if (i <= 3) begin
                check("b2b_start", 32'(start4), 1);
                check("b2b_data", 32'(fir_data4), 32'(i));
            end
        end
        drive(1'b0, '0);
        repeat (6) @(negedge clk);
        check("latency19", 32'(first_v4 - acc19), 3);
        check("q4_size", 32'(q4.size()), 6);
        for (int k = 0; k < 6; k++) check("q4_data", q4_at(k), 32'(19 + 4 * k));
        check("q1_size", 32'(q1.size()), 22);
        check("q1_first", q1_at(0), 19);
        check("q1_last", q1_at(21), 40);
        check("run_ovf4", 32'(ovf4), 0);
        check("run_ovf1", 32'(ovf1), 0);

        // Backpressure: captures 41..48
        set_ready(1'b0);
        for (int i = 41; i <= 48; i++) begin
            drive(1'b1, W'(i));
            @(negedge clk);
        end
        drive(1'b0, '0);
        repeat (5) @(negedge clk);
        check("bp_valid4", 32'(io4.out_valid_o), 1);
        check("bp_data4", 32'(io4.out_data_o), 43);
        check("bp_ovf4", 32'(ovf4), 1);
        check("bp_data1", 32'(io1.out_data_o), 41);
        check("bp_ovf1", 32'(ovf1), 1);
        check("bp_q4_size", 32'(q4.size()), 6);

        set_ready(1'b1);
        @(negedge clk);
        check("xfer_valid4", 32'(io4.out_valid_o), 0);
        check("xfer_hold4", 32'(io4.out_data_o), 43);
        check("xfer_ovf4", 32'(ovf4), 1);
        check("xfer_q4", q4_at(6), 43);
        check("xfer_q1", q1_at(22), 41);
        check("xfer_ovf1", 32'(ovf1), 1);
`ifdef FIR_DECIM_CTRL_STATS_EN
        check("stat_in4", inc4, 48);
        check("stat_drop4", 32'(drc4), 1);
        check("stat_in1", inc1, 48);
        check("stat_drop1", 32'(drc1), 7);
`endif

        // Enable drop clears overflow; then abort a fill after 10 captures
        enable = 1'b0;
        @(negedge clk);
        check("dis_ovf4", 32'(ovf4), 0);
        check("dis_ovf1", 32'(ovf1), 0);
        check("dis_ready", 32'(io4.sample_ready_o), 0);
        enable = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, W'(100 + i));
            @(negedge clk);
        end
        drive(1'b0, '0);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);

        // Fresh warm-up: captures 59..98, first emit at 77
        for (int i = 1; i <= 40; i++) begin
            drive(1'b1, W'(200 + i));
            @(negedge clk);
        end
        drive(1'b0, '0);
        repeat (6) @(negedge clk);
        check("re_q4_size", 32'(q4.size()), 13);
        for (int k = 0; k < 6; k++) check("re_q4_data", q4_at(7 + k), 32'(77 + 4 * k));
        check("re_q1_size", 32'(q1.size()), 45);
        check("re_q1_first", q1_at(23), 77);
        check("re_ovf4", 32'(ovf4), 0);

        // Asynchronous reset in the middle of traffic
        set_ready(1'b0);
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, W'(16'h1230 + i));
            @(negedge clk);
        end
        check("pre_rst_start", 32'(start4), 1);
        check("pre_rst_valid1", 32'(io1.out_valid_o), 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_ctl4", 32'({io4.sample_ready_o, start4, merge4, io4.out_valid_o, ovf4}), 0);
        check("arst_fir4", 32'(fir_data4), 0);
        check("arst_out4", 32'(io4.out_data_o), 0);
        check("arst_ctl1", 32'({io1.sample_ready_o, start1, merge1, io1.out_valid_o, ovf1}), 0);
        check("arst_fir1", 32'(fir_data1), 0);
        check("arst_out1", 32'(io1.out_data_o), 0);
`ifdef FIR_DECIM_CTRL_STATS_EN
        check("arst_stat4", inc4 | 32'(drc4), 0);
        check("arst_stat1", inc1 | 32'(drc1), 0);
`endif
        drive(1'b0, '0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
